// File: rtl/mixcol_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// One GF(2^8) multiplier is reused over the 16 byte-products of a column; four
// byte accumulators collect the XOR sums. Optional product register (MUL_PIPE)
// skews accumulation by one edge.
module mixcol_seq #(
  parameter int unsigned MUL_PIPE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  input  logic        in_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      col_q, col_d;
  logic             inv_q, inv_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0][7:0]  acc_q, acc_d;

  logic [1:0] row;
  logic [1:0] col;
  logic [1:0] coef_sel;
  logic [7:0] coef;
  logic [7:0] s_c;
  logic [7:0] prod;
  logic       accept;

  // Datapath into the accumulators; selected by the MUL_PIPE variant below.
  logic       issue;
  logic       acc_en;
  logic [1:0] acc_row;
  logic [7:0] acc_val;
  logic       acc_last;

  // GF(2^8) multiply, field polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  assign row      = idx_q[3:2];
  assign col      = idx_q[1:0];
  assign coef_sel = col - row;  // (c - r) mod 4 via 2-bit wrap
  assign accept   = in_valid && (state_q == StIdle);

  // Matrix coefficient and column byte for the current product.
  always_comb begin
    coef = 8'h00;
    case ({inv_q, coef_sel})
      3'b000:  coef = 8'h02;
      3'b001:  coef = 8'h03;
      3'b010:  coef = 8'h01;
      3'b011:  coef = 8'h01;
      3'b100:  coef = 8'h0e;
      3'b101:  coef = 8'h0b;
      3'b110:  coef = 8'h0d;
      3'b111:  coef = 8'h09;
      default: coef = 8'h00;
    endcase
    s_c = 8'h00;
    case (col)
      2'd0:    s_c = col_q[31:24];
      2'd1:    s_c = col_q[23:16];
      2'd2:    s_c = col_q[15:8];
      2'd3:    s_c = col_q[7:0];
      default: s_c = 8'h00;
    endcase
  end

  assign prod = gf_mul(coef, s_c);

  if (MUL_PIPE == 0) begin : g_comb_mac
    assign issue    = (state_q == StCalc);
    assign acc_en   = issue;
    assign acc_row  = row;
    assign acc_val  = prod;
    assign acc_last = (idx_q == 4'hf);
  end else begin : g_pipe_mac
    logic [7:0] prod_q;
    logic [1:0] prow_q;
    logic       pv_q;
    logic       plast_q;
    logic       issued_q;  // all 16 products launched; drain the last one

    assign issue = (state_q == StCalc) && !issued_q;

    // Product register: carries one product and its row to the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q   <= 8'h00;
        prow_q   <= 2'd0;
        pv_q     <= 1'b0;
        plast_q  <= 1'b0;
        issued_q <= 1'b0;
      end else if (accept) begin
        prod_q   <= 8'h00;
        prow_q   <= 2'd0;
        pv_q     <= 1'b0;
        plast_q  <= 1'b0;
        issued_q <= 1'b0;
      end else begin
        pv_q <= issue;
        if (issue) begin
          prod_q  <= prod;
          prow_q  <= row;
          plast_q <= (idx_q == 4'hf);
          if (idx_q == 4'hf) issued_q <= 1'b1;
        end
      end
    end

    assign acc_en   = (state_q == StCalc) && pv_q;
    assign acc_row  = prow_q;
    assign acc_val  = prod_q;
    assign acc_last = plast_q;
  end

  // Next-state: FSM, column/mode latch, index counter and accumulators.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    inv_d   = inv_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          col_d   = in_col;
          inv_d   = in_inv;
          idx_d   = 4'd0;
          acc_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Index saturates at 15; only a new accept clears it.
        if (issue && (idx_q != 4'hf)) idx_d = idx_q + 4'd1;
        if (acc_en) begin
          acc_d[acc_row] = acc_q[acc_row] ^ acc_val;
          if (acc_last) state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= 32'h0;
      inv_q   <= 1'b0;
      idx_q   <= 4'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_col   = {acc_q[0], acc_q[1], acc_q[2], acc_q[3]};

endmodule

// File: tb/tb_mixcol_seq.sv
// Directed bench for mixcol_seq: one instance per MUL_PIPE setting, known AES
// MixColumns vectors, latency, backpressure, back-to-back and mid-op reset.
module tb_mixcol_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [31:0] in_col  [2];
  logic [31:0] out_col [2];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter for spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  mixcol_seq #(.MUL_PIPE(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_col    (in_col[0]),
    .in_inv    (in_inv[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_col   (out_col[0]),
    .busy      (busy[0])
  );

  mixcol_seq #(.MUL_PIPE(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_col    (in_col[1]),
    .in_inv    (in_inv[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_col   (out_col[1]),
    .busy      (busy[1])
  );

  // Hand-computed vectors: column, mode, expected result.
  logic [31:0] v_col [7] = '{32'hDB135345, 32'hD4BF5D30, 32'hF20A225C, 32'h01010101,
                             32'hC6C6C6C6, 32'h8E4DA1BC, 32'h046681E5};
  logic        v_inv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] v_res [7] = '{32'h8E4DA1BC, 32'h046681E5, 32'h9FDC589D, 32'h01010101,
                             32'hC6C6C6C6, 32'hDB135345, 32'hD4BF5D30};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One column with out_ready held high; checks latency, result, 1-cycle pulse.
  task automatic run_col(input int sel, input logic [31:0] col, input logic inv,
                         input logic [31:0] exp);
    int lat;
    in_col[sel]    = col;
    in_inv[sel]    = inv;
    in_valid[sel]  = 1'b1;
    out_ready[sel] = 1'b1;
    check_eq($sformatf("d%0d_in_ready_idle", sel), 32'(in_ready[sel]), 32'd1);
    @(negedge clk);
    in_valid[sel] = 1'b0;
    in_col[sel]   = ~col;
    in_inv[sel]   = ~inv;
    check_eq($sformatf("d%0d_busy_calc", sel), 32'(busy[sel]), 32'd1);
    check_eq($sformatf("d%0d_in_ready_calc", sel), 32'(in_ready[sel]), 32'd0);
    lat = 0;
    while (!out_valid[sel] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq($sformatf("d%0d_latency", sel), 32'(lat), 32'(16 + sel));
    check_eq($sformatf("d%0d_out_col_%h", sel, col), out_col[sel], exp);
    @(negedge clk);
    check_eq($sformatf("d%0d_valid_pulse", sel), 32'(out_valid[sel]), 32'd0);
    check_eq($sformatf("d%0d_in_ready_next", sel), 32'(in_ready[sel]), 32'd1);
  endtask

  // Result held under backpressure while FFFFFFFF pulses are offered.
  task automatic backpressure(input int sel, input logic [31:0] col, input logic [31:0] exp);
    int waited;
    in_col[sel]    = col;
    in_inv[sel]    = 1'b0;
    in_valid[sel]  = 1'b1;
    out_ready[sel] = 1'b0;
    @(negedge clk);
    in_valid[sel] = 1'b0;
    in_col[sel]   = 32'hFFFFFFFF;
    waited = 0;
    while (!out_valid[sel] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check_eq($sformatf("d%0d_bp_valid_seen", sel), 32'(out_valid[sel]), 32'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid[sel] = (i % 2 == 0);
      @(negedge clk);
      check_eq($sformatf("d%0d_bp_hold_col", sel), out_col[sel], exp);
      check_eq($sformatf("d%0d_bp_in_ready", sel), 32'(in_ready[sel]), 32'd0);
      check_eq($sformatf("d%0d_bp_valid_hold", sel), 32'(out_valid[sel]), 32'd1);
    end
    in_valid[sel]  = 1'b0;
    out_ready[sel] = 1'b1;
    @(negedge clk);
    check_eq($sformatf("d%0d_bp_valid_drop", sel), 32'(out_valid[sel]), 32'd0);
    check_eq($sformatf("d%0d_bp_in_ready_next", sel), 32'(in_ready[sel]), 32'd1);
    check_eq($sformatf("d%0d_bp_no_capture", sel), out_col[sel], exp);
  endtask

  // Continuous traffic: spacing between successive out_valid rises.
  task automatic back_to_back(input int sel);
    int unsigned t1;
    int unsigned t2;
    int waited;
    in_col[sel]    = 32'hDB135345;
    in_inv[sel]    = 1'b0;
    in_valid[sel]  = 1'b1;
    out_ready[sel] = 1'b1;
    waited = 0;
    while (!out_valid[sel] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    t1 = cyc;
    check_eq($sformatf("d%0d_b2b_first", sel), out_col[sel], 32'h8E4DA1BC);
    @(negedge clk);
    waited = 0;
    while (!out_valid[sel] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    t2 = cyc;
    in_valid[sel] = 1'b0;
    check_eq($sformatf("d%0d_b2b_spacing", sel), t2 - t1, 32'(18 + sel));
    check_eq($sformatf("d%0d_b2b_second", sel), out_col[sel], 32'h8E4DA1BC);
    repeat (2) @(negedge clk);
    check_eq($sformatf("d%0d_b2b_idle", sel), 32'(busy[sel]), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n      = 1'b0;
    in_valid   = '0;
    out_ready  = '0;
    in_inv     = '0;
    in_col[0]  = 32'h0;
    in_col[1]  = 32'h0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_eq($sformatf("d%0d_rst_in_ready", s), 32'(in_ready[s]), 32'd1);
      check_eq($sformatf("d%0d_rst_out_valid", s), 32'(out_valid[s]), 32'd0);
      check_eq($sformatf("d%0d_rst_busy", s), 32'(busy[s]), 32'd0);
      check_eq($sformatf("d%0d_rst_out_col", s), out_col[s], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 7; v++) run_col(s, v_col[v], v_inv[v], v_res[v]);
    end

    backpressure(0, 32'hD4BF5D30, 32'h046681E5);
    backpressure(1, 32'hF20A225C, 32'h9FDC589D);

    // Reset during CALC at idx 7 on the MUL_PIPE=0 instance.
    in_col[0]    = 32'hDB135345;
    in_inv[0]    = 1'b0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("rst_mid_busy_before", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("rst_mid_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_mid_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst_mid_out_col", out_col[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    check_eq("rst_mid_no_valid", 32'(seen), 32'd0);
    run_col(0, 32'hF20A225C, 1'b0, 32'h9FDC589D);

    back_to_back(0);
    back_to_back(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
